// File: rtl/adc_cfg_pkg.sv
// Shared constants, FSM state type and slice helper for the ADC configuration loader.
package adc_cfg_pkg;

    localparam int unsigned N_ADC    = 16;
    localparam int unsigned CFG_W    = 71;
    localparam int unsigned REG_W    = 1280;
    localparam int unsigned MASK_LSB = 1136;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SCAN,
        ST_ISSUE,
        ST_DONE
    } load_state_e;

    // Bit offset of ADC n's configuration word inside the SPI register.
    function automatic int unsigned slice_off(input int unsigned n);
        return n * CFG_W;
    endfunction

endpackage

// File: rtl/adc_config_loader_if.sv
// Configuration delivery channel from the loader to the ADC array (valid/ready).
interface adc_config_loader_if;
    import adc_cfg_pkg::*;

    logic [CFG_W-1:0] cfg_data;
    logic [3:0]       cfg_adc;
    logic             cfg_valid;
    logic             cfg_ready;

    modport master (
        output cfg_data,
        output cfg_adc,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_adc,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/cdc_sync.sv
// Parameterized-depth single-bit synchronizer with a selectable reset value.
module cdc_sync #(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {DEPTH{RESET_VAL}};
        end else begin
            sr[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/adc_config_loader.sv
// Snapshots the SPI configuration register when chip select deasserts and
// delivers each enabled ADC's configuration word over a valid/ready channel.
module adc_config_loader #(
    parameter int unsigned N_ADC       = adc_cfg_pkg::N_ADC,
    parameter int unsigned CFG_W       = adc_cfg_pkg::CFG_W,
    parameter int unsigned REG_W       = adc_cfg_pkg::REG_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_cs_b,
    input  logic [REG_W-1:0]           spi_bits,
    adc_config_loader_if.master        cfg,
    output logic                       busy,
    output logic                       load_done,
    output logic [4:0]                 load_count
);
    import adc_cfg_pkg::*;

    localparam int unsigned SHADOW_W = MASK_LSB + N_ADC;

    logic cs_sync;
    logic cs_hist;
    logic cs_rise;

    cdc_sync #(
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi_cs_b),
        .q   (cs_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cs_hist <= 1'b1;
        else     cs_hist <= cs_sync;
    end

    assign cs_rise = cs_sync & ~cs_hist;

    load_state_e           state;
    load_state_e           state_n;
    logic [SHADOW_W-1:0]   shadow;
    logic [3:0]            idx;
    logic [4:0]            cnt;
    logic [4:0]            last_cnt;
    logic                  pending;
    logic [N_ADC-1:0]      mask;
    logic                  last_idx;
    logic [CFG_W-1:0]      word [N_ADC];

    // Spare register bits above the enable mask are never consumed.
    logic spare_unused;
    assign spare_unused = ^spi_bits[REG_W-1:SHADOW_W];

    assign mask     = shadow[MASK_LSB +: N_ADC];
    assign last_idx = (idx == 4'(N_ADC - 1));

    for (genvar g = 0; g < N_ADC; g++) begin : g_word
        assign word[g] = shadow[slice_off(g) +: CFG_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_adc   = '0;
        cfg.cfg_data  = '0;
        load_done     = 1'b0;
        load_count    = last_cnt;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (cs_rise) state_n = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_n = ST_SCAN;
            end
            ST_SCAN: begin
                if (mask[idx])     state_n = ST_ISSUE;
                else if (last_idx) state_n = ST_DONE;
            end
            ST_ISSUE: begin
                cfg.cfg_valid = 1'b1;
                cfg.cfg_adc   = idx;
                cfg.cfg_data  = word[idx];
                if (cfg.cfg_ready) state_n = last_idx ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                load_done  = 1'b1;
                load_count = cnt;
                state_n    = pending ? ST_CAPTURE : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            idx      <= '0;
            cnt      <= '0;
            last_cnt <= '0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    shadow <= spi_bits[SHADOW_W-1:0];
                    idx    <= '0;
                    cnt    <= '0;
                end
                ST_SCAN: begin
                    if (!mask[idx] && !last_idx) idx <= idx + 4'd1;
                end
                ST_ISSUE: begin
                    if (cfg.cfg_ready) begin
                        cnt <= cnt + 5'd1;
                        if (!last_idx) idx <= idx + 4'd1;
                    end
                end
                ST_DONE: begin
                    last_cnt <= cnt;
                end
                default: ;
            endcase
        end
    end

    // Leaving DONE with pending set goes straight to CAPTURE, which already
    // samples the newest register contents, so a coincident edge is absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (state == ST_DONE) begin
            pending <= pending ? 1'b0 : cs_rise;
        end else if (state != ST_IDLE && cs_rise) begin
            pending <= 1'b1;
        end
    end

endmodule
